mult_arbiter: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 24 ++
 rtl/mult_arbiter_rr_arbiter.sv | 46 ++++
 rtl/mult_arbiter.sv | 101 ++++++++++
 tb/tb_mult_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter slice.
package mult_arb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int MULT_LAT_DEF = 3;
    localparam int STAT_W       = 16;
    localparam int ID_MAX_W     = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // id is sized for the largest supported NREQ; narrower configs use the low bits
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin grant over NREQ requesters; the search starts at the pointer and wraps.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            gnt_vld_o,
    output logic [ID_W-1:0] gnt_id_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    int unsigned     idx;

    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        gnt_id_o  = '0;
        idx       = 0;
        if (!rst_i) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = (int'(ptr_q) + i) % NREQ;
                if (!gnt_vld_o && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    gnt_vld_o  = 1'b1;
                    gnt_id_o   = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = (gnt_id_o == ID_W'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one fixed-latency multiplier among NREQ requesters with round-robin grants.
// Optional per-requester grant counters: define MULT_ARBITER_STATS_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int ID_W     = clog2(NREQ),
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        mult_a,
    output logic [7:0]        mult_b,
    input  logic [15:0]       mult_result,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [15:0]       rsp_data
`ifdef MULT_ARBITER_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NREQ*STAT_W-1:0]   stat_grants
`endif
);

    localparam int DATA_W = 8;

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    tag_t            tag_d;
    tag_t            tag_q [MULT_LAT];

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
        .clk       (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        mult_a = '0;
        mult_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                mult_a = req_a[k*DATA_W +: DATA_W];
                mult_b = req_b[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        tag_d.valid = gnt_vld;
        tag_d.id    = ID_MAX_W'(gnt_id);
    end

    // Tags ride alongside the multiplier pipeline; clearing them masks stale products
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < MULT_LAT; j++) tag_q[j] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int j = 1; j < MULT_LAT; j++) tag_q[j] <= tag_q[j-1];
        end
    end

    assign rsp_valid = tag_q[MULT_LAT-1].valid;
    assign rsp_id    = tag_q[MULT_LAT-1].id[ID_W-1:0];
    assign rsp_data  = mult_result;

`ifdef MULT_ARBITER_STATS_EN
    logic [STAT_W-1:0] stat_q [NREQ];
    logic [STAT_W-1:0] stat_d [NREQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            stat_d[k] = stat_q[k];
            if (stat_clr)                      stat_d[k] = '0;
            else if (gnt[k] && stat_q[k] != '1) stat_d[k] = stat_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (rst) stat_q[k] <= '0;
            else     stat_q[k] <= stat_d[k];
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int k = 0; k < NREQ; k++) stat_grants[k*STAT_W +: STAT_W] = stat_q[k];
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural grant/response model.
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_a, req_b;
    logic [3:0]  gnt;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] mult_result;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
`ifdef MULT_ARBITER_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_grants;
    int          gcnt [NREQ];
`endif

    mult_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef MULT_ARBITER_STATS_EN
        , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // Environment: the shared pipelined multiplier, no reset inside
    logic [15:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= 16'(mult_a) * 16'(mult_b);
        for (int j = 1; j < LAT; j++) mp[j] <= mp[j-1];
    end
    assign mult_result = mp[LAT-1];

    typedef struct { int due; int id; int prod; } exp_t;
    exp_t q[$];
    int   mptr = 0;
    int   cyc = 0;
    int   vectors = 0;
    int   fails = 0;

    logic [3:0]  eg;
    logic [7:0]  ea, eb;
    logic        ev;
    logic [1:0]  eid;
    logic [15:0] ed;

    function automatic int model_grant(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // Predicts this cycle's outputs from current inputs and advances model state
    task automatic eval_cycle();
        int k;
        eg = '0; ea = '0; eb = '0; ev = 1'b0; eid = '0; ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1'b1; eid = 2'(q[0].id); ed = 16'(q[0].prod);
            void'(q.pop_front());
        end
        if (rst) begin
            q.delete();
            mptr = 0;
`ifdef MULT_ARBITER_STATS_EN
            for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
`endif
        end else begin
            k = model_grant(req, mptr);
            if (k >= 0) begin
                eg[k] = 1'b1;
                ea = req_a[8*k +: 8];
                eb = req_b[8*k +: 8];
                q.push_back('{cyc + LAT, k, int'(ea) * int'(eb)});
                mptr = (k + 1) % NREQ;
            end
`ifdef MULT_ARBITER_STATS_EN
            if (stat_clr) begin
                for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
            end else if (k >= 0 && gcnt[k] < 65535) begin
                gcnt[k] = gcnt[k] + 1;
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_a = '0; req_b = '0;
        @(negedge clk); eval_cycle();
        @(posedge clk); #1; cyc++;
        @(negedge clk); eval_cycle();
        vectors++;
        if (gnt !== 4'b0 || mult_a !== 8'd0 || mult_b !== 8'd0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_state gnt=%b a=%0d b=%0d v=%b id=%0d required 0000/0/0/0/0", gnt, mult_a, mult_b, rsp_valid, rsp_id);
        end
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        for (int c = 0; c < 5; c++) begin
            req = (c == 0) ? 4'b0001 : 4'b0000;
            req_a = {24'h0, 8'd12}; req_b = {24'h0, 8'd13};
            @(negedge clk); eval_cycle();
            vectors++;
            if (gnt !== eg) begin fails++; $display("FAIL single_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
            if (mult_a !== ea || mult_b !== eb) begin fails++; $display("FAIL single_ops got=%0d,%0d exp=%0d,%0d", mult_a, mult_b, ea, eb); end
            if (rsp_valid !== ev) begin fails++; $display("FAIL single_vld cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
            if (ev && (rsp_id !== eid || rsp_data !== ed)) begin fails++; $display("FAIL single_rsp got=%0d/%0d exp=%0d/%0d", rsp_id, rsp_data, eid, ed); end
            if (c == 3) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd156) begin
                    fails++; $display("FAIL single_lat3 got v=%b id=%0d d=%0d exp 1/0/156", rsp_valid, rsp_id, rsp_data);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_fairness();
        for (int c = 0; c < 13; c++) begin
            rst = (c == 0);
            req = (c <= 8) ? 4'b1111 : 4'b0000;
            req_a = $urandom; req_b = $urandom;
            @(negedge clk); eval_cycle();
            vectors++;
            if (gnt !== eg) begin fails++; $display("FAIL fair_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
            if (mult_a !== ea || mult_b !== eb) begin fails++; $display("FAIL fair_ops got=%0d,%0d exp=%0d,%0d", mult_a, mult_b, ea, eb); end
            if (rsp_valid !== ev) begin fails++; $display("FAIL fair_vld cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
            if (ev && (rsp_id !== eid || rsp_data !== ed)) begin fails++; $display("FAIL fair_rsp got=%0d/%0d exp=%0d/%0d", rsp_id, rsp_data, eid, ed); end
            if (c >= 1 && c <= 8) begin
                vectors++;
                if (gnt !== 4'(1 << ((c - 1) % 4))) begin fails++; $display("FAIL fair_seq c=%0d got=%b exp=%b", c, gnt, 4'(1 << ((c - 1) % 4))); end
            end
            @(posedge clk); #1; cyc++;
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 7; c++) begin
            req = (c == 0) ? 4'b0100 : (c <= 2) ? 4'b0101 : 4'b0000;
            req_a = $urandom; req_b = $urandom;
            req_a[7:0] = 8'd255; req_b[7:0] = 8'd255;
            @(negedge clk); eval_cycle();
            vectors++;
            if (gnt !== eg) begin fails++; $display("FAIL wrap_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
            if (mult_a !== ea || mult_b !== eb) begin fails++; $display("FAIL wrap_ops got=%0d,%0d exp=%0d,%0d", mult_a, mult_b, ea, eb); end
            if (rsp_valid !== ev) begin fails++; $display("FAIL wrap_vld cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
            if (ev && (rsp_id !== eid || rsp_data !== ed)) begin fails++; $display("FAIL wrap_rsp got=%0d/%0d exp=%0d/%0d", rsp_id, rsp_data, eid, ed); end
            if (c == 1 || c == 2) begin
                vectors++;
                if (gnt !== ((c == 1) ? 4'b0001 : 4'b0100)) begin fails++; $display("FAIL wrap_skip c=%0d got=%b", c, gnt); end
            end
            if (c == 4) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_data !== 16'd65025) begin fails++; $display("FAIL wrap_255sq got=%0d exp=65025", rsp_data); end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 8; c++) begin
            rst = (c == 2);
            req = (c <= 3) ? 4'b1111 : 4'b0000;
            req_a = $urandom; req_b = $urandom;
            @(negedge clk); eval_cycle();
            vectors++;
            if (gnt !== eg) begin fails++; $display("FAIL rstmid_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
            if (mult_a !== ea || mult_b !== eb) begin fails++; $display("FAIL rstmid_ops got=%0d,%0d exp=%0d,%0d", mult_a, mult_b, ea, eb); end
            if (rsp_valid !== ev) begin fails++; $display("FAIL rstmid_vld cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
            if (ev && (rsp_id !== eid || rsp_data !== ed)) begin fails++; $display("FAIL rstmid_rsp got=%0d/%0d exp=%0d/%0d", rsp_id, rsp_data, eid, ed); end
            if (c >= 2 && c <= 5) begin
                vectors++;
                if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_drop c=%0d got v=%b exp 0", c, rsp_valid); end
            end
            if (c == 3) begin
                vectors++;
                if (gnt !== 4'b0001) begin fails++; $display("FAIL rstmid_ptr0 got=%b exp=0001", gnt); end
            end
            @(posedge clk); #1; cyc++;
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nvld;
        nvld = 0;
        for (int c = 0; c < 14; c++) begin
            req = (c < 10) ? 4'b0100 : 4'b0000;
            req_a = $urandom; req_b = $urandom;
            req_a[23:16] = 8'(c); req_b[23:16] = 8'(c + 1);
            @(negedge clk); eval_cycle();
            vectors++;
            if (gnt !== eg) begin fails++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
            if (mult_a !== ea || mult_b !== eb) begin fails++; $display("FAIL b2b_ops got=%0d,%0d exp=%0d,%0d", mult_a, mult_b, ea, eb); end
            if (rsp_valid !== ev) begin fails++; $display("FAIL b2b_vld cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
            if (ev && (rsp_id !== eid || rsp_data !== ed)) begin fails++; $display("FAIL b2b_rsp got=%0d/%0d exp=%0d/%0d", rsp_id, rsp_data, eid, ed); end
            if (rsp_valid === 1'b1) nvld++;
            if (c >= 3 && c <= 12) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'((c - 3) * (c - 2))) begin
                    fails++; $display("FAIL b2b_prod c=%0d got=%b/%0d/%0d exp=1/2/%0d", c, rsp_valid, rsp_id, rsp_data, (c - 3) * (c - 2));
                end
            end
            @(posedge clk); #1; cyc++;
        end
        vectors++;
        if (nvld != 10) begin fails++; $display("FAIL b2b_count got=%0d exp=10", nvld); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            req = 4'($urandom_range(0, 15));
            req_a = $urandom; req_b = $urandom;
            @(negedge clk); eval_cycle();
            vectors++;
            if (gnt !== eg) begin fails++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
            if (mult_a !== ea || mult_b !== eb) begin fails++; $display("FAIL rand_ops got=%0d,%0d exp=%0d,%0d", mult_a, mult_b, ea, eb); end
            if (rsp_valid !== ev) begin fails++; $display("FAIL rand_vld cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
            if (ev && (rsp_id !== eid || rsp_data !== ed)) begin fails++; $display("FAIL rand_rsp got=%0d/%0d exp=%0d/%0d", rsp_id, rsp_data, eid, ed); end
            @(posedge clk); #1; cyc++;
        end
        rst = 1'b0;
    endtask

`ifdef MULT_ARBITER_STATS_EN
    task automatic test_stats();
        for (int c = 0; c < 70002; c++) begin
            stat_clr = (c == 0) || (c == 70001);
            req = (c == 0) ? 4'b0000 : 4'b0010;
            req_a = $urandom; req_b = $urandom;
            @(negedge clk);
            if (c == 1 || c == 500 || c == 70001) begin
                vectors++;
                for (int i = 0; i < NREQ; i++) begin
                    if (stat_grants[16*i +: 16] !== 16'(gcnt[i])) begin
                        fails++; $display("FAIL stat_cnt c=%0d req%0d got=%0d exp=%0d", c, i, stat_grants[16*i +: 16], gcnt[i]);
                    end
                end
            end
            if (c == 70001) begin
                vectors++;
                if (stat_grants[31:16] !== 16'd65535) begin fails++; $display("FAIL stat_sat got=%0d exp=65535", stat_grants[31:16]); end
            end
            eval_cycle();
            vectors++;
            if (gnt !== eg) begin fails++; $display("FAIL stat_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
            if (rsp_valid !== ev) begin fails++; $display("FAIL stat_vld cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
            if (ev && (rsp_id !== eid || rsp_data !== ed)) begin fails++; $display("FAIL stat_rsp got=%0d/%0d exp=%0d/%0d", rsp_id, rsp_data, eid, ed); end
            @(posedge clk); #1; cyc++;
        end
        stat_clr = 1'b0; req = '0;
        @(negedge clk);
        vectors++;
        if (stat_grants[31:16] !== 16'd0) begin fails++; $display("FAIL stat_clr_prio got=%0d exp=0", stat_grants[31:16]); end
        @(posedge clk); #1; cyc++;
    endtask
`endif

    initial begin
`ifdef MULT_ARBITER_STATS_EN
        stat_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
`endif
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_reset_midflight();
        test_back_to_back();
        test_random();
`ifdef MULT_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
